// File: rtl/waveform_shaper_stream.sv
// Streams a source waveform from a sync RAM, shapes each sample per a mode latched at start, writes it to a destination RAM.
// Latency: sample k is written 3 cycles after start (cycle k+3). There is no backpressure: a frame always runs DEPTH+3 cycles once started.
module waveform_shaper_stream #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int TRI_STEP    = 2,
  parameter int FM_MAX_STEP = 20,
  parameter int FM_MIN_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_flg,
  input  logic [3:0]        sw,
  input  logic [DATA_W-1:0] threshold,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              rdy_flg
);

  localparam int STEP_W = $clog2(FM_MAX_STEP + 1);
  localparam int PROD_W = DATA_W + $clog2(FM_MAX_STEP) + 1;
  localparam int TRI_W  = DATA_W + 2;
  localparam logic [DATA_W-1:0] MAXV = '1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  typedef enum logic [2:0] {M_ZERO, M_SINE, M_TRI, M_SQR, M_FM} mode_t;

  state_t state, state_nxt;
  mode_t  mode_q, mode_sel;

  logic [DATA_W-1:0] thr_q;
  logic [ADDR_W-1:0] rd_addr_d;
  logic              rd_vld;
  logic              start_acc;

  logic [DATA_W-1:0] prev_x;
  logic [DATA_W-1:0] tri_y;
  logic              tri_up;
  logic              first;
  logic [STEP_W-1:0] pos;
  logic              fm_bit;

  logic [PROD_W-1:0]       fm_prod;
  logic [PROD_W-1:0]       fm_quot;
  logic [STEP_W-1:0]       fm_step;
  logic [STEP_W-1:0]       pos_n;
  logic                    fm_tog;
  logic                    fm_bit_n;
  logic signed [TRI_W-1:0] tri_prev;
  logic signed [TRI_W-1:0] tri_sum;
  logic                    tri_up_n;
  logic [DATA_W-1:0]       tri_y_n;
  logic [DATA_W-1:0]       shaped;

  assign start_acc = (state == IDLE) && start_flg;
  assign busy      = (state == READ) || (state == DRAIN);
  assign rdy_flg   = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_flg) state_nxt = READ;
      READ:    if (rd_addr == LAST) state_nxt = DRAIN;
      DRAIN:   if (wr_en && (wr_addr == LAST)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mode_sel = M_ZERO;
    case (sw)
      4'b0001: mode_sel = M_SINE;
      4'b0010: mode_sel = M_TRI;
      4'b0100: mode_sel = M_SQR;
      4'b1000: mode_sel = M_FM;
      default: mode_sel = M_ZERO;
    endcase
  end

  // FM half-period shrinks linearly from FM_MAX_STEP (x=0) to FM_MIN_STEP (x=MAXV)
  assign fm_prod  = PROD_W'(rd_data) * PROD_W'(FM_MAX_STEP - FM_MIN_STEP);
  assign fm_quot  = fm_prod / PROD_W'(MAXV);
  assign fm_step  = STEP_W'(FM_MAX_STEP) - STEP_W'(fm_quot);
  assign pos_n    = pos + STEP_W'(1);
  assign fm_tog   = (pos_n >= fm_step);
  assign fm_bit_n = fm_bit ^ fm_tog;

  // Two headroom bits let the step overshoot either rail before it is clamped
  always_comb begin
    tri_up_n = tri_up;
    if (!first) begin
      if (rd_data > prev_x)      tri_up_n = 1'b1;
      else if (rd_data < prev_x) tri_up_n = 1'b0;
    end
    tri_prev = signed'(TRI_W'(tri_y));
    tri_sum  = tri_up_n ? (tri_prev + TRI_W'(TRI_STEP)) : (tri_prev - TRI_W'(TRI_STEP));
    if (first)                 tri_y_n = rd_data;
    else if (tri_sum[TRI_W-1]) tri_y_n = '0;
    else if (tri_sum[DATA_W])  tri_y_n = MAXV;
    else                       tri_y_n = tri_sum[DATA_W-1:0];
  end

  always_comb begin
    shaped = '0;
    case (mode_q)
      M_SINE:  shaped = rd_data;
      M_TRI:   shaped = tri_y_n;
      M_SQR:   shaped = (rd_data >= thr_q) ? MAXV : '0;
      M_FM:    shaped = fm_bit_n ? MAXV : '0;
      default: shaped = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= M_ZERO;
      thr_q     <= '0;
      rd_addr   <= '0;
      rd_addr_d <= '0;
      rd_vld    <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      prev_x    <= '0;
      tri_y     <= '0;
      tri_up    <= 1'b0;
      first     <= 1'b0;
      pos       <= '0;
      fm_bit    <= 1'b0;
    end else begin
      // rd_vld tracks the RAM's one-cycle read latency
      rd_vld    <= (state == READ);
      rd_addr_d <= rd_addr;
      wr_en     <= rd_vld;
      if (start_acc) begin
        mode_q  <= mode_sel;
        thr_q   <= threshold;
        rd_addr <= '0;
        pos     <= '0;
        fm_bit  <= 1'b0;
        tri_up  <= 1'b1;
        first   <= 1'b1;
      end else if ((state == READ) && (rd_addr != LAST)) begin
        rd_addr <= rd_addr + ADDR_W'(1);
      end
      if (rd_vld) begin
        wr_addr <= rd_addr_d;
        wr_data <= shaped;
        prev_x  <= rd_data;
        tri_y   <= tri_y_n;
        tri_up  <= tri_up_n;
        first   <= 1'b0;
        pos     <= fm_tog ? '0 : pos_n;
        fm_bit  <= fm_bit_n;
      end
    end
  end

endmodule
